// File: rtl/versatile_fifo_pkg.sv
// versatile_fifo_pkg: shared constants and types for the SD data-path FIFO controller
//   AW/DW/DEPTH : RAM geometry (2048 x 8)
//   ptr_t       : RAM address, lvl_t : word count up to DEPTH+2, data_t : one word
package versatile_fifo_pkg;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW+1:0] lvl_t;
    typedef logic [DW-1:0] data_t;
endpackage

// File: rtl/versatile_fifo_out_buf.sv
// versatile_fifo_out_buf: 2-entry capture/pop buffer presenting the valid/ready read side
//   clk, rst     : clock, async active-high reset
//   i_clr        : synchronous flush
//   i_cap        : i_cap_data is written into the buffer at this edge
//   i_pop        : consumer takes the head word at this edge
//   o_valid      : head word present, o_data : head word
//   o_cnt        : words held, o_cnt_nxt : words held after this edge
module versatile_fifo_out_buf
    import versatile_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_cap,
    input  data_t      i_cap_data,
    input  logic       i_pop,
    output logic       o_valid,
    output data_t      o_data,
    output logic [1:0] o_cnt,
    output logic [1:0] o_cnt_nxt
);
    logic [1:0] r_cnt;
    data_t      r_d0;
    data_t      r_d1;
    logic       w_pop;
    logic [1:0] w_wpos;
    assign w_pop     = i_pop & (r_cnt != 2'd0);
    // slot the captured word lands in once the head has (possibly) left
    assign w_wpos    = r_cnt - {1'b0, w_pop};
    assign o_cnt_nxt = i_clr ? 2'd0 : r_cnt + {1'b0, i_cap} - {1'b0, w_pop};
    assign o_valid   = r_cnt != 2'd0;
    assign o_data    = r_d0;
    assign o_cnt     = r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else if (i_clr) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else begin
            r_cnt <= o_cnt_nxt;
            r_d0  <= (i_cap && w_wpos == 2'd0) ? i_cap_data : (w_pop ? r_d1 : r_d0);
            r_d1  <= (i_cap && w_wpos == 2'd1) ? i_cap_data : r_d1;
        end
    end
endmodule

// File: rtl/versatile_fifo_sync_ctrl.sv
// versatile_fifo_sync_ctrl: single-clock FIFO controller for the 2048x8 dual-port RAM
//   clk, rst, clr          : clock, async active-high reset, synchronous flush
//   wr_en, wr_data, full   : push side; pushes while full are dropped
//   rd_valid, rd_ready, rd_data : pop side fed by a 2-word prefetch buffer
//   level, almost_full, almost_empty, overflow : fill status
//   ram_*_a                : RAM write port, ram_*_b / ram_q_b : RAM read port
module versatile_fifo_sync_ctrl
    import versatile_fifo_pkg::*;
#(
    parameter int AFULL_TH  = 2040,
    parameter int AEMPTY_TH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  wr_en,
    input  data_t wr_data,
    output logic  full,
    output logic  rd_valid,
    input  logic  rd_ready,
    output data_t rd_data,
    output lvl_t  level,
    output logic  almost_full,
    output logic  almost_empty,
    output logic  overflow,
    output ptr_t  ram_adr_a,
    output data_t ram_d_a,
    output logic  ram_we_a,
    output ptr_t  ram_adr_b,
    output data_t ram_d_b,
    output logic  ram_we_b,
    input  data_t ram_q_b
);
    ptr_t       r_wr_ptr;
    ptr_t       r_rd_ptr;
    lvl_t       r_mem_cnt;
    lvl_t       r_level;
    logic       r_rd_pend;
    logic       r_full;
    logic       r_afull;
    logic       r_aempty;
    logic       r_overflow;
    logic       w_push;
    logic       w_pop;
    logic       w_issue;
    logic [1:0] w_buf_cnt;
    logic [1:0] w_buf_cnt_nxt;
    logic [2:0] w_occ;
    lvl_t       w_mem_cnt_nxt;
    lvl_t       w_level_nxt;
    assign w_pop  = rd_valid & rd_ready;
    assign w_push = wr_en & ~r_full & ~clr;
    // buffer slots still claimed after this edge; prefetch only while one is free
    assign w_occ   = {1'b0, w_buf_cnt} + {2'b0, r_rd_pend} - {2'b0, w_pop};
    // mem_cnt holds committed words only, so a word is never read in its write cycle
    assign w_issue = (r_mem_cnt != '0) & (w_occ < 3'd2) & ~clr;
    assign w_mem_cnt_nxt = clr ? '0 : r_mem_cnt + lvl_t'(w_push) - lvl_t'(w_issue);
    assign w_level_nxt   = w_mem_cnt_nxt + lvl_t'(w_issue) + lvl_t'(w_buf_cnt_nxt);
    assign ram_adr_a    = r_wr_ptr;
    assign ram_d_a      = wr_data;
    assign ram_we_a     = w_push;
    assign ram_adr_b    = r_rd_ptr;
    assign ram_d_b      = '0;
    assign ram_we_b     = 1'b0;
    assign full         = r_full;
    assign level        = r_level;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_overflow;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_level    <= '0;
            r_rd_pend  <= 1'b0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= clr ? '0 : r_wr_ptr + ptr_t'(w_push);
            r_rd_ptr   <= clr ? '0 : r_rd_ptr + ptr_t'(w_issue);
            r_mem_cnt  <= w_mem_cnt_nxt;
            r_level    <= w_level_nxt;
            r_rd_pend  <= w_issue;
            r_full     <= w_mem_cnt_nxt == lvl_t'(DEPTH);
            r_afull    <= w_level_nxt >= lvl_t'(AFULL_TH);
            r_aempty   <= w_level_nxt <= lvl_t'(AEMPTY_TH);
            r_overflow <= ~clr & (r_overflow | (wr_en & r_full));
        end
    end
    versatile_fifo_out_buf u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (clr),
        .i_cap      (r_rd_pend),
        .i_cap_data (ram_q_b),
        .i_pop      (w_pop),
        .o_valid    (rd_valid),
        .o_data     (rd_data),
        .o_cnt      (w_buf_cnt),
        .o_cnt_nxt  (w_buf_cnt_nxt)
    );
endmodule

// File: tb/tb_versatile_fifo_sync_ctrl.sv
// tb_versatile_fifo_sync_ctrl: directed checks of the FIFO controller against a RAM model
module tb_versatile_fifo_sync_ctrl;
    import versatile_fifo_pkg::*;
    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  clr = 1'b0;
    logic  wr_en = 1'b0;
    logic  rd_ready = 1'b0;
    data_t wr_data = '0;
    logic  full, rd_valid, almost_full, almost_empty, overflow, ram_we_a, ram_we_b;
    data_t rd_data, ram_d_a, ram_d_b, ram_q_b;
    lvl_t  level;
    ptr_t  ram_adr_a, ram_adr_b;
    data_t mem [0:DEPTH-1];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
        ram_q_b <= mem[ram_adr_b];
    end

    versatile_fifo_sync_ctrl dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .level(level),
        .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
        .ram_adr_a(ram_adr_a), .ram_d_a(ram_d_a), .ram_we_a(ram_we_a),
        .ram_adr_b(ram_adr_b), .ram_d_b(ram_d_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
    );

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rd_valid, full, almost_full, almost_empty, overflow, ram_we_a, ram_we_b} !== 7'b0001000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0001000",
                     {rd_valid, full, almost_full, almost_empty, overflow, ram_we_a, ram_we_b});
        end
        total++;
        if (level !== 13'd0 || rd_data !== 8'h00 || ram_d_b !== 8'h00) begin
            bad++;
            $display("FAIL reset_values level=%0d rd_data=%h ram_d_b=%h exp 0/00/00", level, rd_data, ram_d_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [23:0] din = 24'h332211;
        logic [5:0]  exp_v = 6'b011100;
        rd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k >= 1) begin
                total++;
                if (rd_valid !== exp_v[k-1]) begin
                    bad++;
                    $display("FAIL basic_valid cyc=%0d got=%b exp=%b", k, rd_valid, exp_v[k-1]);
                end
                if (exp_v[k-1]) begin
                    total++;
                    if (rd_data !== din[8*(k-3) +: 8]) begin
                        bad++;
                        $display("FAIL basic_data cyc=%0d got=%h exp=%h", k, rd_data, din[8*(k-3) +: 8]);
                    end
                end
            end
            wr_en = (k < 3);
            if (k < 3) wr_data = din[8*k +: 8];
            @(negedge clk);
        end
        total++;
        if (level !== 13'd0) begin
            bad++;
            $display("FAIL basic_level got=%0d exp=0", level);
        end
    endtask

    task automatic test_full();
        int n = 0;
        rd_ready = 1'b0;
        for (int i = 0; i < 2051; i++) begin
            total++;
            if (level !== lvl_t'(i)) begin
                bad++;
                $display("FAIL fill_level got=%0d exp=%0d", level, i);
            end
            total++;
            if (almost_full !== (level >= 13'd2040) || almost_empty !== (level <= 13'd8)) begin
                bad++;
                $display("FAIL fill_thresholds level=%0d afull=%b aempty=%b", level, almost_full, almost_empty);
            end
            wr_en = 1'b1;
            wr_data = (i == 2050) ? 8'hEE : data_t'(i);
            if (i == 2050) begin
                #1;
                total++;
                if (ram_we_a !== 1'b0) begin
                    bad++;
                    $display("FAIL full_we got=%b exp=0", ram_we_a);
                end
            end
            @(negedge clk);
            if (i == 2048) begin
                total++;
                if (full !== 1'b0) begin
                    bad++;
                    $display("FAIL full_early got=%b exp=0 level=%0d", full, level);
                end
            end
            if (i == 2049) begin
                total++;
                if (full !== 1'b1 || level !== 13'd2050 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL full_at_2050 full=%b level=%0d ovf=%b exp 1/2050/0", full, level, overflow);
                end
            end
        end
        total++;
        if (overflow !== 1'b1 || level !== 13'd2050 || full !== 1'b1) begin
            bad++;
            $display("FAIL overflow ovf=%b level=%0d full=%b exp 1/2050/1", overflow, level, full);
        end
        wr_en = 1'b0;
        rd_ready = 1'b1;
        for (int c = 0; c < 2200; c++) begin
            if (rd_valid) begin
                total++;
                if (rd_data !== data_t'(n)) begin
                    bad++;
                    $display("FAIL drain_data idx=%0d got=%h exp=%h", n, rd_data, data_t'(n));
                end
                n++;
            end
            @(negedge clk);
        end
        total++;
        if (n != 2050 || level !== 13'd0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL drain_count words=%0d level=%0d ovf=%b exp 2050/0/1", n, level, overflow);
        end
    endtask

    task automatic test_clr();
        rd_ready = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_data = 8'h5B;
        @(negedge clk);
        total++;
        if (level !== 13'd2) begin
            bad++;
            $display("FAIL clr_pre_level got=%0d exp=2", level);
        end
        clr = 1'b1;
        wr_data = 8'h5C;
        #1;
        total++;
        if (ram_we_a !== 1'b0) begin
            bad++;
            $display("FAIL clr_we got=%b exp=0", ram_we_a);
        end
        @(negedge clk);
        total++;
        if ({rd_valid, overflow, full, almost_empty} !== 4'b0001 || level !== 13'd0) begin
            bad++;
            $display("FAIL clr_state valid/ovf/full/aempty=%b level=%0d exp 0001/0",
                     {rd_valid, overflow, full, almost_empty}, level);
        end
        clr = 1'b0;
        wr_en = 1'b0;
        rd_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (rd_valid !== 1'b0 || level !== 13'd0) begin
                bad++;
                $display("FAIL clr_dropped cyc=%0d valid=%b level=%0d exp 0/0", c, rd_valid, level);
            end
        end
    endtask

    task automatic test_stream();
        data_t q[$];
        data_t cnt = 8'h00;
        data_t last = 8'h00;
        data_t exp;
        logic  stall = 1'b0;
        for (int c = 0; c < 5020; c++) begin
            total++;
            if (level !== lvl_t'(q.size())) begin
                bad++;
                $display("FAIL stream_level cyc=%0d got=%0d exp=%0d", c, level, q.size());
            end
            if (stall) begin
                total++;
                if (rd_valid !== 1'b1 || rd_data !== last) begin
                    bad++;
                    $display("FAIL stream_stall cyc=%0d valid=%b got=%h exp=%h", c, rd_valid, rd_data, last);
                end
            end
            wr_en = (c < 5000) && ($urandom_range(0, 9) < 7);
            wr_data = cnt;
            rd_ready = (c >= 5000) || ($urandom_range(0, 9) < 8);
            if (wr_en && !full) begin
                q.push_back(cnt);
                cnt++;
            end
            if (rd_valid && rd_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra cyc=%0d got=%h exp=none", c, rd_data);
                end else begin
                    exp = q.pop_front();
                    if (rd_data !== exp) begin
                        bad++;
                        $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, rd_data, exp);
                    end
                end
            end
            stall = rd_valid && !rd_ready;
            last = rd_data;
            @(negedge clk);
        end
        total++;
        if (q.size() != 0 || level !== 13'd0) begin
            bad++;
            $display("FAIL stream_end left=%0d level=%0d exp 0/0", q.size(), level);
        end
    endtask

    task automatic test_async_rst();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = data_t'(8'h40 + i);
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        wr_en = 1'b0;
        #1;
        total++;
        if ({rd_valid, full, almost_full, almost_empty, overflow, ram_we_a} !== 6'b000100 ||
            level !== 13'd0 || rd_data !== 8'h00) begin
            bad++;
            $display("FAIL async_rst flags=%b level=%0d rd_data=%h exp 000100/0/00",
                     {rd_valid, full, almost_full, almost_empty, overflow, ram_we_a}, level, rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'hC3;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_early got=%b exp=0", rd_valid);
        end
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin
            bad++;
            $display("FAIL post_rst_data valid=%b got=%h exp 1/c3", rd_valid, rd_data);
        end
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0 || level !== 13'd0) begin
            bad++;
            $display("FAIL post_rst_empty valid=%b level=%0d exp 0/0", rd_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_clr();
        test_stream();
        test_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
